// File: rtl/branch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_pkg: shared condition codes, state type and alignment helper   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned FALLTHROUGH_INC = 4;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } br_state_e;

  // Low target bits that must be zero for a legal jump destination.
  function automatic logic [1:0] align_mask(input int ialign);
    return (ialign == 16) ? 2'b01 : 2'b11;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_resolve_unit_if: operand/result bus of the branch unit         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface branch_resolve_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  imm;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  next_pc;
  logic             flush;
  logic             illegal;
  logic             misaligned;
  logic             clr_cnt;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output in_valid, funct3, rs1_val, rs2_val, pc, imm, out_ready, clr_cnt,
    input  in_ready, out_valid, taken, target, next_pc, flush, illegal,
           misaligned, br_count, taken_count
  );

  modport slave (
    input  in_valid, funct3, rs1_val, rs2_val, pc, imm, out_ready, clr_cnt,
    output in_ready, out_valid, taken, target, next_pc, flush, illegal,
           misaligned, br_count, taken_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_cmp: combinational RV32I branch condition evaluation           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module branch_cmp
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [2:0]      funct3_i,
  output logic            taken_o,
  output logic            illegal_o
);

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = !lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = !lt_u;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | branch_resolve_unit: registered branch decision, target, flush, stats |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16,
  parameter int IALIGN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_resolve_unit_if.slave bus
);

  br_state_e        state_q, state_d;
  logic             taken_q, illegal_q, misaligned_q;
  logic [XLEN-1:0]  target_q, next_pc_q;
  logic [CNT_W-1:0] br_count_q, taken_count_q;

  logic            cmp_taken, cmp_illegal;
  logic [XLEN-1:0] sum_target, sum_fall;
  logic            mis_comb;
  logic            accept, consume;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1_i     (bus.rs1_val),
    .rs2_i     (bus.rs2_val),
    .funct3_i  (bus.funct3),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );

  assign sum_target = bus.pc + bus.imm;
  assign sum_fall   = bus.pc + XLEN'(FALLTHROUGH_INC);
  assign mis_comb   = cmp_taken & (|(sum_target[1:0] & align_mask(IALIGN)));

  assign bus.out_valid = (state_q == FULL);
  assign bus.in_ready  = !bus.out_valid | bus.out_ready;
  assign accept        = bus.in_valid & bus.in_ready;
  assign consume       = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (consume && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      taken_q      <= 1'b0;
      illegal_q    <= 1'b0;
      misaligned_q <= 1'b0;
      target_q     <= '0;
      next_pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        taken_q      <= cmp_taken;
        illegal_q    <= cmp_illegal;
        misaligned_q <= mis_comb;
        target_q     <= sum_target;
        next_pc_q    <= cmp_taken ? sum_target : sum_fall;
      end
    end
  end

  // Statistics track results the consumer actually took, not accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else if (bus.clr_cnt) begin
      br_count_q    <= '0;
      taken_count_q <= '0;
    end else if (consume && !illegal_q) begin
      br_count_q <= br_count_q + 1'b1;
      if (taken_q) taken_count_q <= taken_count_q + 1'b1;
    end
  end

  assign bus.taken       = taken_q;
  assign bus.illegal     = illegal_q;
  assign bus.misaligned  = misaligned_q;
  assign bus.target      = target_q;
  assign bus.next_pc     = next_pc_q;
  assign bus.flush       = bus.out_valid & taken_q;
  assign bus.br_count    = br_count_q;
  assign bus.taken_count = taken_count_q;

endmodule
`default_nettype wire
